// File: rtl/pipelined_ripple_adder.sv
// Ripple-carry adder split into STAGES slices with a valid/ready pipeline and skew/deskew registers.
// Define ADDER_OVF_EN to add the two's-complement overflow output Ovf.
module pipelined_ripple_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             Clock,
    input  logic             Reset_b,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Out_valid,
`ifdef ADDER_OVF_EN
    output logic             Ovf,
`endif
    input  logic             Out_ready
);
    localparam int SLICE_W = WIDTH / STAGES;

    function automatic logic [SLICE_W:0] slice_add(input logic [SLICE_W-1:0] x,
                                                   input logic [SLICE_W-1:0] y,
                                                   input logic ci);
        return {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, ci};
    endfunction

    // A stage advances when it is full and its successor is empty or advancing itself.
    function automatic logic [STAGES-1:0] advance_chain(input logic [STAGES-1:0] v,
                                                        input logic ordy);
        logic [STAGES-1:0] a;
        a = '0;
        a[STAGES-1] = v[STAGES-1] & ordy;
        for (int k = STAGES - 2; k >= 0; k--) begin
            a[k] = v[k] & (~v[k+1] | a[k+1]);
        end
        return a;
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;

    // Upper operand bits still to be added (right-aligned), sum slices shifted in from the top.
    logic [WIDTH-1:0]  a_p  [STAGES];
    logic [WIDTH-1:0]  b_p  [STAGES];
    logic [WIDTH-1:0]  s_p  [STAGES];
    logic              c_p  [STAGES];

    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic              c_in [STAGES];
    logic [WIDTH-1:0]  a_nx [STAGES];
    logic [WIDTH-1:0]  b_nx [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic              c_nx [STAGES];
    logic [SLICE_W:0]  r_nx [STAGES];

`ifdef ADDER_OVF_EN
    logic              sa_p [STAGES];
    logic              sb_p [STAGES];
`endif

    assign adv      = advance_chain(vld_p, Out_ready);
    assign In_ready = Reset_b & (~vld_p[0] | adv[0]);

    always_comb begin
        ld    = '0;
        ld[0] = In_valid & In_ready;
        for (int k = 1; k < STAGES; k++) begin
            ld[k] = adv[k-1];
        end
    end

    always_comb begin
        a_in[0] = A;
        b_in[0] = B;
        c_in[0] = Cin;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_p[k-1];
            b_in[k] = b_p[k-1];
            c_in[k] = c_p[k-1];
            s_in[k] = s_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            r_nx[k] = slice_add(a_in[k][SLICE_W-1:0], b_in[k][SLICE_W-1:0], c_in[k]);
            c_nx[k] = r_nx[k][SLICE_W];
            a_nx[k] = a_in[k] >> SLICE_W;
            b_nx[k] = b_in[k] >> SLICE_W;
            s_nx[k] = (s_in[k] >> SLICE_W) | (WIDTH'(r_nx[k][SLICE_W-1:0]) << (WIDTH - SLICE_W));
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            vld_p <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld_p[k] <= 1'b1;
                end else if (adv[k]) begin
                    vld_p[k] <= 1'b0;
                end
            end
        end
    end

    // Stage registers; the last stage drops the exhausted operands and is cleared on reset.
    always_ff @(posedge Clock) begin
        for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
                s_p[k] <= s_nx[k];
                c_p[k] <= c_nx[k];
                if (k < STAGES - 1) begin
                    a_p[k] <= a_nx[k];
                    b_p[k] <= b_nx[k];
                end
`ifdef ADDER_OVF_EN
                sa_p[k] <= (k == 0) ? A[WIDTH-1] : sa_p[(k == 0) ? 0 : k - 1];
                sb_p[k] <= (k == 0) ? B[WIDTH-1] : sb_p[(k == 0) ? 0 : k - 1];
`endif
            end
        end
        if (!Reset_b) begin
            s_p[STAGES-1] <= '0;
            c_p[STAGES-1] <= 1'b0;
`ifdef ADDER_OVF_EN
            sa_p[STAGES-1] <= 1'b0;
            sb_p[STAGES-1] <= 1'b0;
`endif
        end
    end

    assign Sum       = s_p[STAGES-1];
    assign Cout      = c_p[STAGES-1];
    assign Out_valid = vld_p[STAGES-1];
`ifdef ADDER_OVF_EN
    assign Ovf = (sa_p[STAGES-1] == sb_p[STAGES-1]) && (s_p[STAGES-1][WIDTH-1] != sa_p[STAGES-1]);
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder: WIDTH=16/STAGES=4 instance plus a STAGES=1 instance.
module tb_pipelined_ripple_adder;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset_b;
    logic [15:0] A, B, Sum;
    logic        Cin, In_valid, In_ready, Cout, Out_valid, Out_ready;
    logic [15:0] A1, B1, Sum1;
    logic        Cin1, In_valid1, In_ready1, Cout1, Out_valid1, Out_ready1;
`ifdef ADDER_OVF_EN
    logic        Ovf, Ovf1;
`endif

    pipelined_ripple_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
        .Clock(Clock), .Reset_b(Reset_b), .A(A), .B(B), .Cin(Cin),
        .In_valid(In_valid), .In_ready(In_ready), .Sum(Sum), .Cout(Cout),
        .Out_valid(Out_valid),
`ifdef ADDER_OVF_EN
        .Ovf(Ovf),
`endif
        .Out_ready(Out_ready)
    );

    pipelined_ripple_adder #(.WIDTH(WIDTH), .STAGES(1)) u_one (
        .Clock(Clock), .Reset_b(Reset_b), .A(A1), .B(B1), .Cin(Cin1),
        .In_valid(In_valid1), .In_ready(In_ready1), .Sum(Sum1), .Cout(Cout1),
        .Out_valid(Out_valid1),
`ifdef ADDER_OVF_EN
        .Ovf(Ovf1),
`endif
        .Out_ready(Out_ready1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    int          out_cycs[$];
    int          checks = 0;
    int          errors = 0;
    int          nacc   = 0;
    int          nout   = 0;
    int          cyc_n  = 0;
    logic [15:0] e_sum;
    logic        e_cout, e_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic [15:0] es, input logic ec, input logic eo);
        In_valid = v; A = a; B = b; Cin = ci;
        e_sum = es; e_cout = ec; e_ovf = eo;
    endtask

    task automatic next_edge();
        @(posedge Clock);
        #1;
    endtask

    always @(posedge Clock) cyc_n++;

    // Scoreboard: expected values travel with accepted inputs, are checked on output transfers.
    always @(negedge Clock) begin
        if (!Reset_b) begin
            exp_q.delete();
        end else begin
            if (Out_valid && Out_ready) begin
                nout++;
                out_cycs.push_back(cyc_n);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: result %h with no pending operation", Sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_sum", Sum, e.sum);
                    chk("out_cout", Cout, e.cout);
`ifdef ADDER_OVF_EN
                    chk("out_ovf", Ovf, e.ovf);
`endif
                end
            end
            if (In_valid && In_ready) begin
                exp_t e;
                e.sum = e_sum; e.cout = e_cout; e.ovf = e_ovf;
                exp_q.push_back(e);
                nacc++;
            end
        end
    end

    vec_t tbl[8];

    initial begin
        int idx, acc0, out0, vcount;
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[4] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[7] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};

        Reset_b = 1'b0;
        Out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        A1 = '0; B1 = '0; Cin1 = 1'b0; In_valid1 = 1'b0; Out_ready1 = 1'b1;

        repeat (3) next_edge();
        @(negedge Clock);
        chk("rst_in_ready", In_ready, 0);
        chk("rst_out_valid", Out_valid, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        chk("rst_s1_in_ready", In_ready1, 0);
        chk("rst_s1_out_valid", Out_valid1, 0);
`ifdef ADDER_OVF_EN
        chk("rst_ovf", Ovf, 0);
`endif
        next_edge();
        Reset_b = 1'b1;
        @(negedge Clock);
        chk("ready_after_reset", In_ready, 1);
        chk("s1_ready_after_reset", In_ready1, 1);
        next_edge();

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf);
            @(negedge Clock);
            chk($sformatf("vec%0d_in_ready", i), In_ready, 1);
            next_edge();
            In_valid = 1'b0;
            for (int j = 1; j <= STAGES; j++) begin
                @(negedge Clock);
                if (j < STAGES) begin
                    chk($sformatf("vec%0d_early_valid", i), Out_valid, 0);
                end else begin
                    chk($sformatf("vec%0d_valid", i), Out_valid, 1);
                    chk($sformatf("vec%0d_sum", i), Sum, tbl[i].sum);
                    chk($sformatf("vec%0d_cout", i), Cout, tbl[i].cout);
`ifdef ADDER_OVF_EN
                    chk($sformatf("vec%0d_ovf", i), Ovf, tbl[i].ovf);
`endif
                end
                next_edge();
            end
        end

        out_cycs.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i), 16'(2 * i), i[0], 16'(3 * i + (i & 1)), 1'b0, 1'b0);
            @(negedge Clock);
            chk("b2b_in_ready", In_ready, 1);
            next_edge();
        end
        In_valid = 1'b0;
        repeat (6) next_edge();
        chk("b2b_count", out_cycs.size(), 8);
        for (int k = 1; k < out_cycs.size(); k++) begin
            chk("b2b_gap", out_cycs[k] - out_cycs[k-1], 1);
        end
        chk("b2b_drained", exp_q.size(), 0);

        Out_ready = 1'b0;
        idx = 0;
        acc0 = nacc;
        out0 = nout;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 16'h1000 + 16'(idx), 16'h2000, 1'b1, 16'h3001 + 16'(idx), 1'b0, 1'b0);
            @(negedge Clock);
            if (In_ready) idx++;
            if (Out_valid) begin
                chk("stall_hold_sum", Sum, 16'h3001);
                chk("stall_hold_cout", Cout, 0);
            end
            next_edge();
        end
        drive(1'b1, 16'h1000 + 16'(idx), 16'h2000, 1'b1, 16'h3001 + 16'(idx), 1'b0, 1'b0);
        @(negedge Clock);
        chk("stall_accepted", nacc - acc0, 4);
        chk("stall_in_ready", In_ready, 0);
        chk("stall_out_valid", Out_valid, 1);
        chk("stall_sum", Sum, 16'h3001);
        next_edge();
        Out_ready = 1'b1;
        drive(1'b1, 16'h1000 + 16'(idx), 16'h2000, 1'b1, 16'h3001 + 16'(idx), 1'b0, 1'b0);
        @(negedge Clock);
        chk("full_in_out_ready", In_ready, 1);
        next_edge();
        In_valid = 1'b0;
        repeat (6) next_edge();
        chk("stall_outputs", nout - out0, 5);
        chk("stall_drained", exp_q.size(), 0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0AAA + 16'(i), 16'h0111, 1'b0, 16'h0BBB + 16'(i), 1'b0, 1'b0);
            @(negedge Clock);
            chk("flush_in_ready", In_ready, 1);
            next_edge();
        end
        Reset_b = 1'b0;
        In_valid = 1'b0;
        @(negedge Clock);
        chk("flush_rst_ready", In_ready, 0);
        next_edge();
        Reset_b = 1'b1;
        @(negedge Clock);
        chk("flush_out_valid", Out_valid, 0);
        chk("flush_sum", Sum, 0);
        out0 = nout;
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            next_edge();
            @(negedge Clock);
            if (Out_valid) vcount++;
        end
        chk("flush_no_stale", vcount, 0);
        chk("flush_no_output", nout - out0, 0);
        next_edge();

        A1 = 16'h1234; B1 = 16'h4321; Cin1 = 1'b1; In_valid1 = 1'b1;
        @(negedge Clock);
        chk("s1_in_ready", In_ready1, 1);
        next_edge();
        In_valid1 = 1'b0;
        @(negedge Clock);
        chk("s1_valid", Out_valid1, 1);
        chk("s1_sum", Sum1, 16'h5556);
        chk("s1_cout", Cout1, 0);
`ifdef ADDER_OVF_EN
        chk("s1_ovf", Ovf1, 0);
`endif
        next_edge();
        @(negedge Clock);
        chk("s1_consumed", Out_valid1, 0);
        next_edge();
        A1 = 16'hFFFF; B1 = 16'h0001; Cin1 = 1'b0; In_valid1 = 1'b1;
        next_edge();
        A1 = 16'h0001; B1 = 16'h0001; Cin1 = 1'b0;
        @(negedge Clock);
        chk("s1_b2b_ready", In_ready1, 1);
        chk("s1_b2b_valid0", Out_valid1, 1);
        chk("s1_b2b_sum0", Sum1, 16'h0000);
        chk("s1_b2b_cout0", Cout1, 1);
        next_edge();
        In_valid1 = 1'b0;
        @(negedge Clock);
        chk("s1_b2b_valid1", Out_valid1, 1);
        chk("s1_b2b_sum1", Sum1, 16'h0002);
        chk("s1_b2b_cout1", Cout1, 0);
        next_edge();

        chk("final_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
